// File: rtl/kbd_pkg.sv
// kbd_pkg: shared scancode constants, discard list, prefix FSM states and event record
package kbd_pkg;
  localparam logic [7:0] KBD_E0 = 8'hE0;
  localparam logic [7:0] KBD_F0 = 8'hF0;
  localparam logic [7:0] KBD_E1 = 8'hE1;
  localparam logic [7:0] KBD_DISCARD [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} kbd_state_e;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;
  function automatic logic is_discard(logic [7:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) r = r | (b == KBD_DISCARD[i]);
    return r;
  endfunction
endpackage

// File: rtl/kbd_evfifo.sv
// kbd_evfifo: DEPTH-entry event FIFO; head presented on o_dout, zero while empty
// ports: clk, rst (sync, active high), i_push/i_din write, i_pop read, o_dout head, o_full, o_empty
module kbd_evfifo import kbd_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  kbd_event_t i_din,
  output kbd_event_t o_dout,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  kbd_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  // a pop frees the slot in the same cycle, so push into a full FIFO is fine then
  assign w_wr   = i_push && (!o_full || i_pop);
  assign w_rd   = i_pop && !o_empty;
  assign o_dout = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/kbd_decode.sv
// kbd_decode: PS/2 scancode prefix decoder producing {code, ext, brk} key events
// ports: clk, rst (sync, active high), kd/kv byte input, ev_code/ev_ext/ev_brk/ev_valid/ev_ready
//        event handshake, ovf sticky drop flag
// KBD_DECODE_FIFO_EN defined: FIFO_DEPTH-entry event FIFO; undefined: single event register
module kbd_decode import kbd_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kd,
  input  logic       kv,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf
);
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_depth
    $error("kbd_decode: FIFO_DEPTH must be 2..16");
  end
  kbd_state_e r_state, w_next;
  logic [2:0] r_skip;
  logic       w_emit, w_pfx, w_push, w_pop, w_full;
  kbd_event_t w_ev, w_head;
  assign w_pfx = kd == KBD_E0 || kd == KBD_F0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_skip  <= '0;
    end else if (kv) begin
      r_state <= w_next;
      r_skip  <= (r_state == S_IDLE && kd == KBD_E1) ? 3'd7 : r_state == S_PAUSE ? r_skip - 3'd1 : r_skip;
    end
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = kd == KBD_E0 ? S_EXT : kd == KBD_F0 ? S_BRK : kd == KBD_E1 ? S_PAUSE : S_IDLE;
      S_EXT:   w_next = kd == KBD_F0 ? S_EXT_BRK : kd == KBD_E0 ? S_EXT : S_IDLE;
      S_PAUSE: w_next = r_skip == 3'd1 ? S_IDLE : S_PAUSE;
      default: w_next = S_IDLE;
    endcase
  end
  // the pause sequence collapses into a single E1 event on its last byte
  always_comb begin
    w_emit      = kv && (r_state == S_IDLE  ? !w_pfx && kd != KBD_E1 && !is_discard(kd) :
                         r_state == S_PAUSE ? r_skip == 3'd1 : !w_pfx);
    w_ev.ext    = r_state == S_EXT || r_state == S_EXT_BRK;
    w_ev.brk    = r_state == S_BRK || r_state == S_EXT_BRK;
    w_ev.code   = r_state == S_PAUSE ? KBD_E1 : kd;
  end
  assign w_pop  = ev_valid && ev_ready;
  assign w_push = w_emit && (!w_full || w_pop);
`ifdef KBD_DECODE_FIFO_EN
  logic w_empty;
  kbd_evfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_ev),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign ev_valid = !w_empty;
`else
  kbd_event_t r_ev;
  logic       r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ev    <= '0;
    end else if (w_push) begin
      r_valid <= 1'b1;
      r_ev    <= w_ev;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end
  assign w_full   = r_valid;
  assign w_head   = r_ev;
  assign ev_valid = r_valid;
`endif
  assign {ev_ext, ev_brk, ev_code} = w_head;
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (w_emit && w_full && !w_pop) ovf <= 1'b1;
  end
endmodule

// File: tb/tb_kbd_decode.sv
// tb_kbd_decode: randomized and directed checks of kbd_decode against a flag-based reference model
module tb_kbd_decode;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kd = '0;
  logic       kv = 1'b0;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext, ev_brk, ev_valid, ovf;
  int         n_chk = 0;
  int         n_pass = 0;
`ifdef KBD_DECODE_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic [9:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  int         m_pause = 0;

  kbd_decode #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .kd(kd), .kv(kv),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit discard(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF;
  endfunction

  // byte -> optional event {ext, brk, code}, tracked as pending prefix flags
  task automatic decode(input logic [7:0] b, output bit has, output logic [9:0] e);
    has = 0;
    e = '0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin has = 1; e = {2'b00, 8'hE1}; end
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (!discard(b)) begin has = 1; e = {2'b00, b}; end
    end else if (b == 8'hF0 || b == 8'hE0) begin
      if (m_brk) begin m_ext = 0; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
    end else begin
      has = 1;
      e = {m_ext, m_brk, b};
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic step(input logic k, input logic [7:0] d, input logic r, input logic rs);
    bit         has, pop;
    logic [9:0] e;
    kv = k; kd = d; ev_ready = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete(); m_ovf = 0; m_ext = 0; m_brk = 0; m_pause = 0;
    end else begin
      has = 0;
      pop = r && m_q.size() > 0;
      if (k) decode(d, has, e);
      if (has && m_q.size() == CAP && !pop) m_ovf = 1;
      if (pop) void'(m_q.pop_front());
      if (has && m_q.size() < CAP) m_q.push_back(e);
    end
    #1;
    chk("valid", ev_valid, m_q.size() > 0);
    chk("ovf", ovf, m_ovf);
    if (m_q.size() > 0) chk("event", {ev_ext, ev_brk, ev_code}, m_q[0]);
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    step(1, d, r, 0);
  endtask

  initial begin
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_out", {ev_valid, ev_ext, ev_brk, ev_code, ovf}, '0);
    send(8'h1C, 1);
    chk("make_1c", {ev_valid, ev_ext, ev_brk, ev_code}, {3'b100, 8'h1C});
    step(0, 0, 1, 0);
    chk("make_1c_gone", ev_valid, 1'b0);
    send(8'hE0, 1);
    send(8'hF0, 1);
    chk("prefix_quiet", ev_valid, 1'b0);
    send(8'h75, 1);
    chk("ext_brk", {ev_valid, ev_ext, ev_brk, ev_code}, {3'b111, 8'h75});
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) send(seq[i], 1);
    chk("pause", {ev_valid, ev_ext, ev_brk, ev_code}, {3'b100, 8'hE1});
    send(8'h1C, 1);
    chk("after_pause", {ev_valid, ev_code}, {1'b1, 8'h1C});
    step(0, 0, 1, 0);
    send(8'hE0, 1);
    step(0, 0, 1, 1);
    send(8'h1C, 1);
    chk("rst_abandon", {ev_valid, ev_ext, ev_code}, {2'b10, 8'h1C});
    step(0, 0, 1, 0);
    send(8'hAA, 1);
    send(8'hFA, 1);
    chk("discard", ev_valid, 1'b0);
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    chk("overflow", ovf, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    chk("drained", ev_valid, 1'b0);
    step(0, 0, 0, 1);
    send(8'h10, 0);
    send(8'h11, 0);
    chk("hold_10", ev_code, 8'h10);
    send(8'h12, 1);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 7))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h14;
        3: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFE;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 1), b, $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kbd_decode.md
KBD_DECODE -- requirements
Module: kbd_decode

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO depth (power of two, 2..16); used only when KBD_DECODE_FIFO_EN is defined.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 kd  input  8  received scancode byte from the keyboard receiver.
REQ-005 kv  input  1  one-cycle strobe; kd is valid in the same cycle.
REQ-006 ev_code  output  8  key code of the presented event.
REQ-007 ev_ext  output  1  event was E0-prefixed.
REQ-008 ev_brk  output  1  1 = key release (F0-prefixed), 0 = key press.
REQ-009 ev_valid  output  1  an event is presented; held until accepted.
REQ-010 ev_ready  input  1  consumer accepts the event when ev_valid && ev_ready at posedge clk.
REQ-011 ovf  output  1  sticky flag; an event was dropped because storage was full.

Function
REQ-012 The prefix FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and PAUSE; it advances only on cycles with kv=1.
REQ-013 In IDLE: E0->EXT, F0->BRK, E1->PAUSE with skip counter = 7, any other byte emits {code, ext=0, brk=0} and stays in IDLE.
REQ-014 In EXT: F0->EXT_BRK, E0 stays EXT, any other byte emits {code, ext=1, brk=0} and goes to IDLE.
REQ-015 In BRK: any byte other than E0/F0 emits {code, ext=0, brk=1} and goes to IDLE; E0 or F0 goes to IDLE with nothing emitted (malformed).
REQ-016 In EXT_BRK: any byte other than E0/F0 emits {code, ext=1, brk=1} and goes to IDLE; E0/F0 goes to IDLE with nothing emitted.
REQ-017 In PAUSE: each kv decrements the 3-bit skip counter; on the byte that brings it to 0 the FSM emits {code=E1, ext=0, brk=0} once and goes to IDLE.
REQ-018 Bytes 00, AA, EE, FA, FC, FD, FE and FF received in IDLE SHALL be discarded without emitting an event; in any other state they are handled as ordinary bytes.
REQ-019 Emit-to-ev_valid latency SHALL be exactly one cycle when storage is empty.
REQ-020 An event is dropped when storage is full and no pop occurs in the same cycle. A drop sets ovf and leaves the FSM transition unaffected.
REQ-021 A simultaneous push and pop on a full FIFO SHALL succeed with no drop.
REQ-022 ev_code, ev_ext and ev_brk SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-023 ovf SHALL clear only on reset.

Reset
REQ-024 On rst: FSM=IDLE, skip counter=0, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, ovf=0.
REQ-025 rst takes priority over kv and ev_ready in the same cycle. A prefix sequence interrupted by rst SHALL be abandoned, and the next byte is decoded from IDLE.

Configuration
REQ-026 Macro KBD_DECODE_FIFO_EN defined: events are buffered in a FIFO_DEPTH-entry FIFO with 10-bit entries {ext, brk, code}.
REQ-027 KBD_DECODE_FIFO_EN undefined: a single output register holds one event and FIFO_DEPTH is ignored. A new event is accepted when the register is empty or is popped in the same cycle; otherwise it is dropped.

Structure
REQ-028 The shared package kbd_pkg SHALL hold the prefix constants (E0, F0, E1), the discard-byte list, the FSM state enum and the kbd_event_t struct {ext, brk, code[7:0]}.
REQ-029 The event storage SHALL be one sub-module, kbd_evfifo, parameterised by depth, with push/pop/full/empty ports. It is instantiated only under KBD_DECODE_FIFO_EN.

Verification
REQ-030 kv with kd=1C, ev_ready=1 -> one cycle later ev_valid=1 for one cycle with code=1C, ext=0, brk=0.
REQ-031 Bytes E0,F0,75 with ev_ready=1 -> exactly one event: code=75, ext=1, brk=1; no event for the prefix bytes.
REQ-032 Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event with code=E1; the following byte 1C decodes normally.
REQ-033 FIFO_EN, depth 4, ev_ready=0, six make codes 01..06 -> ovf=1; draining yields 01,02,03,04, then ev_valid=0.
REQ-034 Bytes E0 then rst then 1C -> event code=1C, ext=0; bytes AA and FA received in IDLE -> no event.
REQ-035 Macro undefined, ev_ready=0, codes 10,11 -> ev_code stays 10, ovf=1; with ev_ready=1 and a push in the same cycle -> no drop.
